// File: rtl/noc_eject_arbiter.sv
// noc_eject_arbiter: collects ejected flits from every flattened-butterfly node
// into per-node 2-entry FIFOs and serialises them onto one valid/ready host
// port using a round-robin arbiter. Each node gets a registered off (stop)
// signal and a sticky overflow flag.
module noc_eject_arbiter #(
  parameter  int DATA_W       = 8,
  parameter  int NODE_PER_ROW = 4,
  parameter  int NODE_PER_COL = 4,
  localparam int N            = NODE_PER_ROW * NODE_PER_COL,
  localparam int ID_W         = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [0:N-1]        valid_i_NoC,
  input  logic [0:DATA_W*N-1] data_i_NoC,
  output logic [0:N-1]        off_sigs_o_NoC,
  output logic                host_valid_o,
  input  logic                host_ready_i,
  output logic [DATA_W-1:0]   host_data_o,
  output logic [ID_W-1:0]     host_src_o,
  output logic [0:N-1]        overflow_o
);

  // Per-node FIFO storage: head is the oldest entry, tail the second one.
  logic [DATA_W-1:0] r_head [N];
  logic [DATA_W-1:0] r_tail [N];
  logic [1:0]        r_occ  [N];
  logic [0:N-1]      r_off;
  logic [0:N-1]      r_ovf;

  logic              r_hvalid;
  logic [DATA_W-1:0] r_hdata;
  logic [ID_W-1:0]   r_hsrc;
  logic [ID_W-1:0]   r_rr;

  logic [DATA_W-1:0] w_head_nxt [N];
  logic [DATA_W-1:0] w_tail_nxt [N];
  logic [1:0]        w_occ_nxt  [N];
  logic [N-1:0]      w_drop;
  logic [N-1:0]      w_pop;
  logic [N-1:0]      w_nonempty;

  logic              w_load;
  logic              w_grant;
  logic              w_found;
  logic [ID_W-1:0]   w_winner;
  logic [ID_W:0]     w_scan_idx;
  logic [ID_W:0]     w_rr_inc;
  logic [ID_W-1:0]   w_rr_nxt;

  // Output register may take a new flit when empty or being accepted this cycle.
  always_comb begin
    w_load  = !r_hvalid || host_ready_i;
    w_grant = w_load && w_found;
  end

  // Round-robin scan: first non-empty node starting at r_rr, wrapping mod N.
  always_comb begin
    w_found    = 1'b0;
    w_winner   = '0;
    w_scan_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_scan_idx = {1'b0, r_rr} + (ID_W+1)'(k);
      if (w_scan_idx >= (ID_W+1)'(N)) w_scan_idx = w_scan_idx - (ID_W+1)'(N);
      if (!w_found && w_nonempty[w_scan_idx[ID_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_scan_idx[ID_W-1:0];
      end
    end
  end

  // Pointer moves to the slot after the winner, wrapping at N.
  always_comb begin
    w_rr_inc = {1'b0, w_winner} + (ID_W+1)'(1);
    w_rr_nxt = (w_rr_inc >= (ID_W+1)'(N)) ? '0 : w_rr_inc[ID_W-1:0];
  end

  // Per-node status and pop strobes derived from the grant.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      w_nonempty[i] = (r_occ[i] != 2'd0);
      w_pop[i]      = w_grant && (w_winner == ID_W'(i));
    end
  end

  // FIFO next state: push/pop combinations; a full FIFO drops only without a pop.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      w_head_nxt[i] = r_head[i];
      w_tail_nxt[i] = r_tail[i];
      w_occ_nxt[i]  = r_occ[i];
      w_drop[i]     = 1'b0;
      case ({valid_i_NoC[i], w_pop[i]})
        2'b10: begin
          case (r_occ[i])
            2'd0: begin
              w_head_nxt[i] = data_i_NoC[i*DATA_W +: DATA_W];
              w_occ_nxt[i]  = 2'd1;
            end
            2'd1: begin
              w_tail_nxt[i] = data_i_NoC[i*DATA_W +: DATA_W];
              w_occ_nxt[i]  = 2'd2;
            end
            default: w_drop[i] = 1'b1;
          endcase
        end
        2'b01: begin
          w_head_nxt[i] = r_tail[i];
          w_occ_nxt[i]  = r_occ[i] - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps occupancy; the new flit lands behind any remaining entry.
          if (r_occ[i] == 2'd1) begin
            w_head_nxt[i] = data_i_NoC[i*DATA_W +: DATA_W];
          end else begin
            w_head_nxt[i] = r_tail[i];
            w_tail_nxt[i] = data_i_NoC[i*DATA_W +: DATA_W];
          end
        end
        default: ;
      endcase
    end
  end

  // FIFO state, registered off signals and sticky overflow flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head <= '{default: '0};
      r_tail <= '{default: '0};
      r_occ  <= '{default: '0};
      r_off  <= '0;
      r_ovf  <= '0;
    end else begin
      r_head <= w_head_nxt;
      r_tail <= w_tail_nxt;
      r_occ  <= w_occ_nxt;
      for (int unsigned i = 0; i < N; i++) begin
        r_off[i] <= (w_occ_nxt[i] != 2'd0);
        r_ovf[i] <= r_ovf[i] | w_drop[i];
      end
    end
  end

  // Host output register and round-robin pointer; everything holds while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hvalid <= 1'b0;
      r_hdata  <= '0;
      r_hsrc   <= '0;
      r_rr     <= '0;
    end else if (w_load) begin
      r_hvalid <= w_found;
      if (w_found) begin
        r_hdata <= r_head[w_winner];
        r_hsrc  <= w_winner;
        r_rr    <= w_rr_nxt;
      end
    end
  end

  assign off_sigs_o_NoC = r_off;
  assign overflow_o     = r_ovf;
  assign host_valid_o   = r_hvalid;
  assign host_data_o    = r_hdata;
  assign host_src_o     = r_hsrc;

endmodule

// File: doc/noc_eject_arbiter.md
Name: noc_eject_arbiter

Overview:
- Collects ejected flits from all NODE_PER_ROW*NODE_PER_COL flattened-butterfly nodes and serialises them onto one host port with valid/ready handshake.
- Buffers each node in a 2-entry FIFO and returns per-node off (backpressure) signals to the routers.
- Shares the host port among nodes with a round-robin arbiter.
- Uses the same flattened bus format as the splitter, so it sits directly on the NoC ejection side.

Parameters:
- DATA_W, 8, flit payload width
- NODE_PER_ROW, 4, nodes per row
- NODE_PER_COL, 4, nodes per column
- N (localparam), NODE_PER_ROW*NODE_PER_COL, node count
- ID_W (localparam), $clog2(N) with minimum 1, source-id width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- valid_i_NoC  in  [0:N-1]  per-node flit valid; bit i = node i
- data_i_NoC  in  [0:DATA_W*N-1]  flattened flits; node i = bits [i*DATA_W +: DATA_W], so node 0 is leftmost
- off_sigs_o_NoC  out  [0:N-1]  per-node stop request, registered
- host_valid_o  out  1  output flit valid
- host_ready_i  in  1  host accepts flit
- host_data_o  out  DATA_W  output flit
- host_src_o  out  ID_W  index of the source node of host_data_o
- overflow_o  out  [0:N-1]  sticky per-node flit-drop flag

Behaviour:
- Reset (rst=0, asynchronous):
  - All FIFOs empty.
  - off_sigs_o_NoC=0, host_valid_o=0, host_data_o=0, host_src_o=0, overflow_o=0.
  - rr_ptr=0.
  - Output is held while rst=0. The first update happens on the first rising edge after rst=1.
- FIFO per node: depth 2, occupancy counter 0..2.
  - Push when valid_i_NoC[i]=1.
  - Pop when node i wins arbitration.
  - Push and pop in the same cycle leave occupancy unchanged, FIFO order is preserved, and a push at occ=2 with a pop is accepted.
  - Push at occ=2 without a pop drops the flit and sets overflow_o[i]=1. The flag stays set until reset.
- Backpressure:
  - off_sigs_o_NoC[i] is registered and equals (next occupancy >= 1).
  - Routers may send one more flit in the first cycle off is high (one-cycle reaction lag). The second FIFO entry absorbs it.
  - off deasserts the cycle after the FIFO drains to 0.
- Output stage: one register (host_valid_o/host_data_o/host_src_o).
  - Load condition: load = !host_valid_o || host_ready_i.
  - When load=1 and any FIFO is non-empty:
    - The winner is the first non-empty node scanning rr_ptr, rr_ptr+1, ... N-1, 0, ... (mod N).
    - The winner's head is loaded with host_src_o=winner and host_valid_o=1, the head is popped, and rr_ptr becomes (winner+1) mod N.
  - When load=1 and all FIFOs are empty: host_valid_o becomes 0, and host_data_o and host_src_o hold their values.
  - When load=0: all output registers hold, no pop, rr_ptr holds.
  - Arbitration considers only entries already stored. A flit arriving on this edge is not eligible this cycle.
- Latency:
  - A flit sampled at edge k appears on host_valid_o after edge k+1 at the earliest.
  - Sustained throughput is 1 flit/cycle when host_ready_i=1.
- Fairness: with all N nodes continuously non-empty and ready=1, each node is granted exactly once per N consecutive grants.
- Per-node ordering is preserved. There is no ordering guarantee between different nodes.
- host_valid_o, once high, is not withdrawn and its data does not change until host_ready_i=1 (AXI-style stability).
- Asserting reset mid-transfer discards all buffered flits and the output flit.

Test Plan:
- Reset/idle: rst=0 for 3 cycles, then rst=1 with no inputs → all outputs 0 for 10 cycles; overflow_o=0.
- Single flit: valid_i_NoC bit 5 for one cycle, node-5 data 8'hA5, ready=1 → host_valid_o=1 one cycle later with data A5, src 5; off_sigs_o_NoC[5] pulses for exactly 1 cycle.
- Round-robin: all 16 valid for one cycle, node i data 8'h10+i, ready=1 → 16 consecutive output flits with src 0,1,...,15 and matching data; off bits clear as each drains.
- Backpressure and stall:
  - Phase 1: ready=0, node 3 sends 3 flits 11,22,33 while honouring off with 1-cycle lag → flit 33 is not sent; output holds 11 stable; FIFO holds 22.
  - Phase 2: ready=1 → outputs 11 then 22; overflow_o[3]=0.
- Overflow: ready=0, node 7 ignores off and sends 4 flits 01..04 → overflow_o[7]=1 and sticky; after ready=1, outputs are 01,02,03 (output reg + 2 FIFO) then valid drops; 04 is lost.
- Fairness under load: nodes 0 and 9 stream continuously, ready toggling 1/0 → grants alternate 0,9,0,9; no src repeats while the other node is non-empty; host_data_o is never changed while valid=1 and ready=0.
